// File: rtl/bus_pkg.sv
// Shared bus definitions: region codes, memory map bounds, FSM states.
// Used by the bus responder and any other master walking the map.
package bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] REG_ROM      = 4'd0;
  localparam logic [3:0] REG_VRAM     = 4'd1;
  localparam logic [3:0] REG_EXTRAM   = 4'd2;
  localparam logic [3:0] REG_WRAM     = 4'd3;
  localparam logic [3:0] REG_OAM      = 4'd4;
  localparam logic [3:0] REG_IO       = 4'd5;
  localparam logic [3:0] REG_HRAM     = 4'd6;
  localparam logic [3:0] REG_IE       = 4'd7;
  localparam logic [3:0] REG_UNMAPPED = 4'd15;

  localparam logic [15:0] ROM_END     = 16'h7FFF;
  localparam logic [15:0] VRAM_BASE   = 16'h8000;
  localparam logic [15:0] VRAM_END    = 16'h9FFF;
  localparam logic [15:0] EXTRAM_BASE = 16'hA000;
  localparam logic [15:0] EXTRAM_END  = 16'hBFFF;
  localparam logic [15:0] WRAM_BASE   = 16'hC000;
  localparam logic [15:0] WRAM_END    = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE   = 16'hE000;
  localparam logic [15:0] ECHO_END    = 16'hFDFF;
  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam logic [15:0] OAM_END     = 16'hFE9F;
  localparam logic [15:0] UNMAP_BASE  = 16'hFEA0;
  localparam logic [15:0] UNMAP_END   = 16'hFEFF;
  localparam logic [15:0] IO_BASE     = 16'hFF00;
  localparam logic [15:0] IO_END      = 16'hFF7F;
  localparam logic [15:0] HRAM_BASE   = 16'hFF80;
  localparam logic [15:0] HRAM_END    = 16'hFFFE;
  localparam logic [15:0] IE_ADDR     = 16'hFFFF;

  localparam logic [15:0] ECHO_OFFSET = 16'h2000;

endpackage

// File: rtl/cpu_bus_responder_if.sv
// CPU-side bus and memory-side req/ack signals of the responder.
// slave = responder view, master = CPU/memory model view.
interface cpu_bus_responder_if;

  logic        i_Address_Out;
  logic [15:0] i_Address;
  logic        i_Bus_In;
  logic        i_Bus_Out;
  logic [7:0]  i_Data;
  logic [7:0]  o_Data;
  logic        o_Data_Valid;
  logic        o_Stall;
  logic        o_Bus_Error;
  logic        o_Mem_Req;
  logic        o_Mem_We;
  logic [3:0]  o_Mem_Region;
  logic [15:0] o_Mem_Addr;
  logic [7:0]  o_Mem_WData;
  logic [7:0]  i_Mem_RData;
  logic        i_Mem_Ack;

  modport slave (
    input  i_Address_Out, i_Address,
    input  i_Bus_In, i_Bus_Out, i_Data,
    input  i_Mem_RData, i_Mem_Ack,
    output o_Data, o_Data_Valid,
    output o_Stall, o_Bus_Error,
    output o_Mem_Req, o_Mem_We,
    output o_Mem_Region, o_Mem_Addr,
    output o_Mem_WData
  );

  modport master (
    output i_Address_Out, i_Address,
    output i_Bus_In, i_Bus_Out, i_Data,
    output i_Mem_RData, i_Mem_Ack,
    input  o_Data, o_Data_Valid,
    input  o_Stall, o_Bus_Error,
    input  o_Mem_Req, o_Mem_We,
    input  o_Mem_Region, o_Mem_Addr,
    input  o_Mem_WData
  );

endinterface

// File: rtl/bus_region_decoder.sv
// Combinational memory-map decoder: address -> region code and
// physical address (echo RAM folded onto WRAM).
module bus_region_decoder
  import bus_pkg::*;
(
  input  logic [15:0] i_Addr,
  output logic [3:0]  o_Region,
  output logic [15:0] o_Phys_Addr
);

  logic w_Echo;

  assign w_Echo = (i_Addr >= ECHO_BASE) &&
                  (i_Addr <= ECHO_END);

  always_comb begin
    o_Region    = REG_UNMAPPED;
    o_Phys_Addr = i_Addr;
    unique case (1'b1)
      (i_Addr <= ROM_END):
        o_Region = REG_ROM;
      (i_Addr >= VRAM_BASE && i_Addr <= VRAM_END):
        o_Region = REG_VRAM;
      (i_Addr >= EXTRAM_BASE && i_Addr <= EXTRAM_END):
        o_Region = REG_EXTRAM;
      (i_Addr >= WRAM_BASE && i_Addr <= WRAM_END):
        o_Region = REG_WRAM;
      w_Echo: begin
        o_Region    = REG_WRAM;
        o_Phys_Addr = i_Addr - ECHO_OFFSET;
      end
      (i_Addr >= OAM_BASE && i_Addr <= OAM_END):
        o_Region = REG_OAM;
      (i_Addr >= UNMAP_BASE && i_Addr <= UNMAP_END):
        o_Region = REG_UNMAPPED;
      (i_Addr >= IO_BASE && i_Addr <= IO_END):
        o_Region = REG_IO;
      (i_Addr >= HRAM_BASE && i_Addr <= HRAM_END):
        o_Region = REG_HRAM;
      (i_Addr == IE_ADDR):
        o_Region = REG_IE;
      default:
        o_Region = REG_UNMAPPED;
    endcase
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side end of the CPU bus: latches the address, decodes the
// region, runs req/ack with memory and stalls the CU until done.
module cpu_bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  cpu_bus_responder_if.slave  bus
);

  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_State,  w_State_Nxt;
  logic [15:0] r_Addr,   w_Addr_Nxt;
  logic [3:0]  r_Region, w_Region_Nxt;
  logic [15:0] r_Phys,   w_Phys_Nxt;
  logic [7:0]  r_Data,   w_Data_Nxt;
  logic        r_Valid,  w_Valid_Nxt;
  logic        r_Stall,  w_Stall_Nxt;
  logic        r_Err,    w_Err_Nxt;
  logic        r_Req,    w_Req_Nxt;
  logic        r_We,     w_We_Nxt;
  logic [7:0]  r_WData,  w_WData_Nxt;
  logic [7:0]  r_Cnt,    w_Cnt_Nxt;
  logic        r_Rd,     w_Rd_Nxt;

  logic        w_Latch;
  logic [15:0] w_Sel_Addr;
  logic [3:0]  w_Dec_Region;
  logic [15:0] w_Dec_Phys;

  // A fresh address presented in IDLE is used by the same-cycle access
  assign w_Latch    = (r_State == S_IDLE) && bus.i_Address_Out;
  assign w_Sel_Addr = w_Latch ? bus.i_Address : r_Addr;

  bus_region_decoder u_dec (
    .i_Addr      (w_Sel_Addr),
    .o_Region    (w_Dec_Region),
    .o_Phys_Addr (w_Dec_Phys)
  );

  always_comb begin
    w_State_Nxt  = r_State;
    w_Addr_Nxt   = r_Addr;
    w_Region_Nxt = r_Region;
    w_Phys_Nxt   = r_Phys;
    w_Data_Nxt   = r_Data;
    w_Valid_Nxt  = 1'b0;
    w_Stall_Nxt  = r_Stall;
    w_Err_Nxt    = 1'b0;
    w_Req_Nxt    = r_Req;
    w_We_Nxt     = r_We;
    w_WData_Nxt  = r_WData;
    w_Cnt_Nxt    = r_Cnt;
    w_Rd_Nxt     = r_Rd;
    unique case (r_State)
      S_IDLE: begin
        if (w_Latch) begin
          w_Addr_Nxt   = bus.i_Address;
          w_Region_Nxt = w_Dec_Region;
          w_Phys_Nxt   = w_Dec_Phys;
        end
        if (bus.i_Bus_In && bus.i_Bus_Out) begin
          w_Err_Nxt = 1'b1;
        end else if (bus.i_Bus_In || bus.i_Bus_Out) begin
          w_Rd_Nxt = bus.i_Bus_In;
          if (w_Dec_Region == REG_UNMAPPED) begin
            w_State_Nxt = S_DONE;
            if (bus.i_Bus_In) begin
              w_Data_Nxt  = OPEN_BUS_VALUE;
              w_Valid_Nxt = 1'b1;
            end
          end else begin
            w_State_Nxt = S_REQ;
            w_Req_Nxt   = 1'b1;
            w_We_Nxt    = bus.i_Bus_Out;
            w_WData_Nxt = bus.i_Data;
            w_Stall_Nxt = 1'b1;
            w_Cnt_Nxt   = 8'd0;
          end
        end
      end
      S_REQ: begin
        if (bus.i_Mem_Ack) begin
          w_State_Nxt = S_DONE;
          w_Req_Nxt   = 1'b0;
          w_Stall_Nxt = 1'b0;
          if (r_Rd) begin
            w_Data_Nxt  = bus.i_Mem_RData;
            w_Valid_Nxt = 1'b1;
          end
        end else if (r_Cnt == LP_TMO_LAST) begin
          w_State_Nxt = S_DONE;
          w_Req_Nxt   = 1'b0;
          w_Stall_Nxt = 1'b0;
          w_Err_Nxt   = 1'b1;
          if (r_Rd) begin
            w_Data_Nxt  = OPEN_BUS_VALUE;
            w_Valid_Nxt = 1'b1;
          end
        end else begin
          w_Cnt_Nxt = r_Cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_State_Nxt = S_IDLE;
      end
      default: begin
        w_State_Nxt = S_IDLE;
        w_Req_Nxt   = 1'b0;
        w_Stall_Nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State  <= S_IDLE;
      r_Addr   <= 16'h0000;
      r_Region <= REG_ROM;
      r_Phys   <= 16'h0000;
      r_Data   <= 8'h00;
      r_Valid  <= 1'b0;
      r_Stall  <= 1'b0;
      r_Err    <= 1'b0;
      r_Req    <= 1'b0;
      r_We     <= 1'b0;
      r_WData  <= 8'h00;
      r_Cnt    <= 8'd0;
      r_Rd     <= 1'b0;
    end else begin
      r_State  <= w_State_Nxt;
      r_Addr   <= w_Addr_Nxt;
      r_Region <= w_Region_Nxt;
      r_Phys   <= w_Phys_Nxt;
      r_Data   <= w_Data_Nxt;
      r_Valid  <= w_Valid_Nxt;
      r_Stall  <= w_Stall_Nxt;
      r_Err    <= w_Err_Nxt;
      r_Req    <= w_Req_Nxt;
      r_We     <= w_We_Nxt;
      r_WData  <= w_WData_Nxt;
      r_Cnt    <= w_Cnt_Nxt;
      r_Rd     <= w_Rd_Nxt;
    end
  end

  assign bus.o_Data       = r_Data;
  assign bus.o_Data_Valid = r_Valid;
  assign bus.o_Stall      = r_Stall;
  assign bus.o_Bus_Error  = r_Err;
  assign bus.o_Mem_Req    = r_Req;
  assign bus.o_Mem_We     = r_We;
  assign bus.o_Mem_Region = r_Region;
  assign bus.o_Mem_Addr   = r_Phys;
  assign bus.o_Mem_WData  = r_WData;

endmodule
